bure_ex_sched: RTL and testbench
================================

# bure_ex_sched

Execute-stage scheduler for the BureCore pipeline. It accepts decoded operations from ID and routes each one. Single-cycle ALU results go straight to the EX output register. RV32M multiply/divide operations are sequenced on the shared iterative M-unit with a cycle counter. While an M-op is in flight the scheduler stalls ID, and it presents exactly one in-order result per accepted op to the next stage over a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- MUL_CYCLES, 4, M-unit iterations for funct3[2]==0 (MUL/MULH/MULHSU/MULHU); must be ≥1
- DIV_CYCLES, 32, M-unit iterations for funct3[2]==1 (DIV/DIVU/REM/REMU); must be ≥1

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_id_valid  in  1  decoded op available
- o_id_ready  out  1  scheduler accepts op this cycle
- i_is_md  in  1  op is an RV32M op (OP opcode, funct7==7'b0000001)
- i_funct3  in  3  op funct3
- i_rd_addr  in  5  destination register
- i_alu_data  in  DATA_WIDTH  combinational ALU result for the current ID op
- i_flush  in  1  kill in-flight and pending work
- o_md_start  out  1  one-cycle pulse: M-unit loads operands and op
- o_md_op  out  3  latched funct3 for the M-unit
- o_md_abort  out  1  one-cycle pulse: M-unit discards its state
- i_md_result  in  DATA_WIDTH  M-unit result, valid in the final counted cycle
- o_ex_valid  out  1  result valid toward MEM/WB
- i_ex_ready  in  1  downstream accepts result
- o_ex_data  out  DATA_WIDTH  result
- o_ex_rd  out  5  destination of result
- o_busy  out  1  M-op in flight (state MD_RUN)

## Operation
- Reset values: o_ex_valid=0, o_ex_data=0, o_ex_rd=0, o_md_start=0, o_md_abort=0, o_md_op=0, state=IDLE, counter=0. The combinational outputs then read o_busy=0, o_id_ready=1.
- o_id_ready = (state==IDLE) && (!o_ex_valid || i_ex_ready) && !i_flush.
- An op is accepted when i_id_valid && o_id_ready.
- States:
  - IDLE: On accept of an ALU op, load o_ex_data←i_alu_data and o_ex_rd←i_rd_addr, and set o_ex_valid. On accept of an M-op, latch o_md_op, rd and the counter, then go to MD_RUN.
  - MD_RUN: The counter is loaded with (funct3[2] ? DIV_CYCLES : MUL_CYCLES)−1 and decrements each cycle. When the counter==0, capture i_md_result and rd into the output register, set o_ex_valid, and go to IDLE.
- o_md_start=1 only in the first MD_RUN cycle (registered pulse).
- Output register: o_ex_valid clears on i_ex_ready unless it is reloaded in the same cycle. The output register is always empty when an M-op completes, because accept required it to be drained and nothing else writes it during MD_RUN.
- Flush:
  - Highest priority.
  - Clears o_ex_valid next cycle and forces IDLE.
  - If asserted in MD_RUN, pulses o_md_abort next cycle and drops the M result.
  - No op is accepted in a flush cycle.
- rd==0 results are emitted normally; writeback discards them.
- Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)). Decrement never wraps, because exit occurs at 0.

## Timing
- ALU op accepted in cycle N: o_ex_valid=1 in N+1. Back-to-back ALU ops sustain 1/cycle while i_ex_ready=1.
- M-op accepted in cycle N:
  - o_md_start and o_busy are high in N+1.
  - Capture happens in N+C, with C = MUL_CYCLES or DIV_CYCLES.
  - o_ex_valid=1 in N+C+1.
  - o_id_ready=0 in N+1..N+C.
  - o_id_ready is 1 again in N+C+1 if i_ex_ready=1.
- C==1: o_md_start and capture happen in the same cycle (N+1).
- Downstream stall (i_ex_ready=0): o_ex_data and o_ex_rd hold stable and o_id_ready=0.
- Asynchronous reset mid-MD_RUN returns all registers to reset values immediately. No o_md_abort pulse is generated; the M-unit shares the reset.

## Structure
- bure_pkg holds:
  - typedef enum logic {IDLE, MD_RUN} bure_ex_sched_state_e
  - localparams for the MD funct3 class bit (MD_DIV_BIT=2)
  - default MUL_CYCLES/DIV_CYCLES
- There are no sub-modules. The FSM, counter and output register are inline; the iterative M-unit is a separate, peer block.

## Test plan
- Reset, then 3 back-to-back ALU ops (rd=1,2,3; data 0x11,0x22,0x33) with i_ex_ready=1 → o_ex_valid high for 3 consecutive cycles carrying 0x11/0x22/0x33 in order.
- MUL (funct3=000, rd=5) accepted at cycle 10, i_md_result=0xDEAD in cycle 14 → o_md_start at 11; o_id_ready=0 in 11..14; o_ex_valid with 0xDEAD, rd=5 at 15.
- DIVU (funct3=101) with DIV_CYCLES=32 accepted at cycle 0 → capture at 32, o_ex_valid at 33; o_busy high 1..32.
- i_ex_ready held 0 for 5 cycles after an ALU result → o_ex_data stable and o_id_ready=0; on release, the next op is accepted in the same cycle.
- i_flush at the 3rd MD_RUN cycle of a DIV → o_md_abort pulse next cycle, state IDLE, no o_ex_valid for that op, and the next ALU op is accepted normally.
- i_flush in the same cycle as i_id_valid for an ALU op, with a prior result pending → the op is not accepted and o_ex_valid=0 the next cycle.

Source files
------------

// File: rtl/bure_ex_sched_pkg.sv
// Shared types and constants for the BureCore execute-stage scheduler.
package bure_pkg;

    typedef enum logic {IDLE, MD_RUN} bure_ex_sched_state_e;

    // funct3 bit that separates the divide class from the multiply class
    localparam int MD_DIV_BIT         = 2;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_MUL_CYCLES     = 4;
    localparam int DEF_DIV_CYCLES     = 32;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bure_ex_sched_if.sv
// ID / M-unit / EX-output signal bundle around the execute-stage scheduler.
interface bure_ex_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_id_valid;
    logic                  o_id_ready;
    logic                  i_is_md;
    logic [2:0]            i_funct3;
    logic [4:0]            i_rd_addr;
    logic [DATA_WIDTH-1:0] i_alu_data;
    logic                  i_flush;
    logic                  o_md_start;
    logic [2:0]            o_md_op;
    logic                  o_md_abort;
    logic [DATA_WIDTH-1:0] i_md_result;
    logic                  o_ex_valid;
    logic                  i_ex_ready;
    logic [DATA_WIDTH-1:0] o_ex_data;
    logic [4:0]            o_ex_rd;
    logic                  o_busy;

    modport slave (
        input  i_id_valid, i_is_md, i_funct3, i_rd_addr, i_alu_data, i_flush,
               i_md_result, i_ex_ready,
        output o_id_ready, o_md_start, o_md_op, o_md_abort, o_ex_valid,
               o_ex_data, o_ex_rd, o_busy
    );

    modport master (
        output i_id_valid, i_is_md, i_funct3, i_rd_addr, i_alu_data, i_flush,
               i_md_result, i_ex_ready,
        input  o_id_ready, o_md_start, o_md_op, o_md_abort, o_ex_valid,
               o_ex_data, o_ex_rd, o_busy
    );
endinterface

// File: rtl/bure_ex_sched.sv
// Execute-stage scheduler: ALU results go straight to the output register,
// RV32M ops are sequenced on the shared iterative M-unit with a down-counter.
module bure_ex_sched
    import bure_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    bure_ex_sched_if.slave   bus
);

    localparam int CNT_MAX = max_int(MUL_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    bure_ex_sched_state_e  state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  ex_valid_reg, ex_valid_next;
    logic [DATA_WIDTH-1:0] ex_data_reg, ex_data_next;
    logic [4:0]            ex_rd_reg, ex_rd_next;
    logic [4:0]            md_rd_reg, md_rd_next;
    logic [2:0]            md_op_reg, md_op_next;
    logic                  md_start_reg, md_start_next;
    logic                  md_abort_reg, md_abort_next;
    logic                  id_ready;
    logic                  accept;

    assign id_ready = (state_reg == IDLE) && (!ex_valid_reg || bus.i_ex_ready) && !bus.i_flush;
    assign accept   = bus.i_id_valid && id_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ex_valid_reg <= 1'b0;
            ex_data_reg  <= '0;
            ex_rd_reg    <= '0;
            md_rd_reg    <= '0;
            md_op_reg    <= '0;
            md_start_reg <= 1'b0;
            md_abort_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ex_valid_reg <= ex_valid_next;
            ex_data_reg  <= ex_data_next;
            ex_rd_reg    <= ex_rd_next;
            md_rd_reg    <= md_rd_next;
            md_op_reg    <= md_op_next;
            md_start_reg <= md_start_next;
            md_abort_reg <= md_abort_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        ex_valid_next = ex_valid_reg;
        ex_data_next  = ex_data_reg;
        ex_rd_next    = ex_rd_reg;
        md_rd_next    = md_rd_reg;
        md_op_next    = md_op_reg;
        md_start_next = 1'b0;
        md_abort_next = 1'b0;

        // A drained result frees the register unless something reloads it below
        if (ex_valid_reg && bus.i_ex_ready) begin
            ex_valid_next = 1'b0;
        end

        if (bus.i_flush) begin
            state_next    = IDLE;
            cnt_next      = '0;
            ex_valid_next = 1'b0;
            md_abort_next = (state_reg == MD_RUN);
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (bus.i_is_md) begin
                            md_op_next    = bus.i_funct3;
                            md_rd_next    = bus.i_rd_addr;
                            cnt_next      = bus.i_funct3[MD_DIV_BIT] ? DIV_LOAD : MUL_LOAD;
                            md_start_next = 1'b1;
                            state_next    = MD_RUN;
                        end else begin
                            ex_data_next  = bus.i_alu_data;
                            ex_rd_next    = bus.i_rd_addr;
                            ex_valid_next = 1'b1;
                        end
                    end
                end
                MD_RUN: begin
                    // Output register is guaranteed empty here: accept required it drained
                    if (cnt_reg == '0) begin
                        ex_data_next  = bus.i_md_result;
                        ex_rd_next    = md_rd_reg;
                        ex_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.o_id_ready = id_ready;
    assign bus.o_md_start = md_start_reg;
    assign bus.o_md_op    = md_op_reg;
    assign bus.o_md_abort = md_abort_reg;
    assign bus.o_ex_valid = ex_valid_reg;
    assign bus.o_ex_data  = ex_data_reg;
    assign bus.o_ex_rd    = ex_rd_reg;
    assign bus.o_busy     = (state_reg == MD_RUN);

endmodule

// File: tb/tb_bure_ex_sched.sv
// Directed bench for bure_ex_sched: scoreboard of expected results, checked as they drain.
module tb_bure_ex_sched;
    localparam int DW   = 32;
    localparam int MULC = 4;
    localparam int DIVC = 32;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [DW+4:0] sb[$];

    bure_ex_sched_if #(.DATA_WIDTH(DW)) bus ();

    bure_ex_sched #(
        .DATA_WIDTH (DW),
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every drained result must match the oldest expected entry
    always @(negedge clk) begin
        if (rstn && bus.o_ex_valid && bus.i_ex_ready && !bus.i_flush) begin
            if (sb.size() == 0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed=%0h expected=none", {bus.o_ex_rd, bus.o_ex_data});
                end
            end else begin
                logic [DW+4:0] e;
                e = sb.pop_front();
                chk("sb_result", {bus.o_ex_rd, bus.o_ex_data}, e);
                $display("result rd=%0d data=%0h expected rd=%0d data=%0h",
                         bus.o_ex_rd, bus.o_ex_data, e[DW+4:DW], e[DW-1:0]);
            end
        end
    end

    task automatic run_md(input logic [2:0] f3, input logic [4:0] rd,
                          input logic [DW-1:0] res, input int ncyc);
        bus.i_id_valid  = 1'b1;
        bus.i_is_md     = 1'b1;
        bus.i_funct3    = f3;
        bus.i_rd_addr   = rd;
        bus.i_md_result = 32'h0BAD;
        @(negedge clk);
        chk("md_accept_ready", bus.o_id_ready, 1);
        sb.push_back({rd, res});
        step();
        bus.i_id_valid = 1'b0;
        bus.i_is_md    = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            bus.i_md_result = (c == ncyc) ? res : 32'h0BAD;
            @(negedge clk);
            chk("md_start", bus.o_md_start, (c == 1));
            chk("md_busy", bus.o_busy, 1);
            chk("md_id_ready_low", bus.o_id_ready, 0);
            if (c == 1) chk("md_op", bus.o_md_op, f3);
            step();
        end
        @(negedge clk);
        chk("md_done_valid", bus.o_ex_valid, 1);
        chk("md_done_busy", bus.o_busy, 0);
        chk("md_done_ready", bus.o_id_ready, 1);
        step();
    endtask

    initial begin
        bus.i_id_valid  = 1'b0;
        bus.i_is_md     = 1'b0;
        bus.i_funct3    = '0;
        bus.i_rd_addr   = '0;
        bus.i_alu_data  = '0;
        bus.i_flush     = 1'b0;
        bus.i_md_result = '0;
        bus.i_ex_ready  = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_ex_valid", bus.o_ex_valid, 0);
        chk("rst_ex_data", bus.o_ex_data, 0);
        chk("rst_ex_rd", bus.o_ex_rd, 0);
        chk("rst_md_start", bus.o_md_start, 0);
        chk("rst_md_abort", bus.o_md_abort, 0);
        chk("rst_md_op", bus.o_md_op, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_id_ready", bus.o_id_ready, 1);
        rstn = 1'b1;
        step();

        // Three back-to-back ALU ops
        for (int k = 1; k <= 3; k++) begin
            bus.i_id_valid = 1'b1;
            bus.i_rd_addr  = 5'(k);
            bus.i_alu_data = DW'(k * 32'h11);
            @(negedge clk);
            chk("alu_id_ready", bus.o_id_ready, 1);
            if (k > 1) chk("alu_stream_valid", bus.o_ex_valid, 1);
            sb.push_back({5'(k), DW'(k * 32'h11)});
            step();
        end
        bus.i_id_valid = 1'b0;
        @(negedge clk);
        chk("alu_last_valid", bus.o_ex_valid, 1);
        step();
        @(negedge clk);
        chk("alu_drained", bus.o_ex_valid, 0);
        step();

        run_md(3'b000, 5'd5, 32'hDEAD, MULC);
        run_md(3'b101, 5'd7, 32'h1234_5678, DIVC);

        // Downstream stall holds the result and blocks ID
        bus.i_ex_ready = 1'b0;
        bus.i_id_valid = 1'b1;
        bus.i_rd_addr  = 5'd9;
        bus.i_alu_data = 32'h99;
        @(negedge clk);
        chk("stall_accept", bus.o_id_ready, 1);
        sb.push_back({5'd9, 32'h99});
        step();
        bus.i_rd_addr  = 5'd10;
        bus.i_alu_data = 32'hAA;
        repeat (5) begin
            @(negedge clk);
            chk("stall_id_ready", bus.o_id_ready, 0);
            chk("stall_data", bus.o_ex_data, 32'h99);
            chk("stall_rd", bus.o_ex_rd, 9);
            step();
        end
        bus.i_ex_ready = 1'b1;
        @(negedge clk);
        chk("release_accept", bus.o_id_ready, 1);
        sb.push_back({5'd10, 32'hAA});
        step();
        bus.i_id_valid = 1'b0;
        step();

        // Flush in the third MD_RUN cycle of a DIV
        bus.i_id_valid  = 1'b1;
        bus.i_is_md     = 1'b1;
        bus.i_funct3    = 3'b100;
        bus.i_rd_addr   = 5'd12;
        bus.i_md_result = 32'h777;
        @(negedge clk);
        chk("div_accept", bus.o_id_ready, 1);
        step();
        bus.i_id_valid = 1'b0;
        bus.i_is_md    = 1'b0;
        step();
        step();
        bus.i_flush = 1'b1;
        @(negedge clk);
        chk("flush_id_ready", bus.o_id_ready, 0);
        chk("flush_busy", bus.o_busy, 1);
        step();
        bus.i_flush    = 1'b0;
        bus.i_id_valid = 1'b1;
        bus.i_rd_addr  = 5'd13;
        bus.i_alu_data = 32'h13;
        @(negedge clk);
        chk("abort_pulse", bus.o_md_abort, 1);
        chk("abort_idle", bus.o_busy, 0);
        chk("abort_no_valid", bus.o_ex_valid, 0);
        chk("abort_id_ready", bus.o_id_ready, 1);
        sb.push_back({5'd13, 32'h13});
        step();
        bus.i_id_valid = 1'b0;
        @(negedge clk);
        chk("abort_one_cycle", bus.o_md_abort, 0);
        chk("post_flush_valid", bus.o_ex_valid, 1);
        step();
        repeat (DIVC + 4) step();
        @(negedge clk);
        chk("dropped_md_result", bus.o_ex_valid, 0);
        step();

        // Flush with a pending result blocks the ALU op
        bus.i_ex_ready = 1'b0;
        bus.i_id_valid = 1'b1;
        bus.i_rd_addr  = 5'd14;
        bus.i_alu_data = 32'h44;
        @(negedge clk);
        chk("pend_accept", bus.o_id_ready, 1);
        step();
        bus.i_rd_addr  = 5'd15;
        bus.i_alu_data = 32'h55;
        bus.i_flush    = 1'b1;
        @(negedge clk);
        chk("flush_blocks_id", bus.o_id_ready, 0);
        chk("pend_valid", bus.o_ex_valid, 1);
        step();
        bus.i_flush    = 1'b0;
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_clears_valid", bus.o_ex_valid, 0);
        step();
        @(negedge clk);
        chk("flushed_op_not_taken", bus.o_ex_valid, 0);
        step();

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
